// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
//   Shares one LED between N_REQ requesters. A round-robin arbiter picks a
//   requester in IDLE, then the FSM plays its burst of blinks (ON/OFF phases of
//   TICK_DIV cycles each), then a GAP of GAP_MULT*TICK_DIV cycles, and reports
//   completion with a one-cycle done pulse tagged with the owner index.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   req_i      request level per requester
//   blinks_i   blink count per requester, requester k at [k*BW +: BW]
//   gnt_o      one-hot one-cycle grant pulse
//   busy_o     high during ON/OFF/GAP
//   done_o     one-cycle pulse at the end of the gap
//   done_id_o  owner index, valid with done_o
//   led_o      registered LED drive
//
// state | meaning
// IDLE  | waiting for a request; grant decision made here
// ON    | LED lit for TICK_DIV cycles
// OFF   | LED dark for TICK_DIV cycles between blinks
// GAP   | LED dark for GAP_MULT*TICK_DIV cycles after the burst

module led_blink_arbiter #(
  parameter int N_REQ    = 4,
  parameter int BW       = 4,
  parameter int TICK_DIV = 12_500_000,
  parameter int GAP_MULT = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*BW-1:0]        blinks_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(N_REQ)-1:0]   done_id_o,
  output logic                       led_o
);

  localparam int IW      = $clog2(N_REQ);
  localparam int GAP_LEN = GAP_MULT * TICK_DIV;
  localparam int PW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              done_q, done_d;
  logic [IW-1:0]     done_id_q, done_id_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [IW-1:0]     pick;
  logic [IW:0]       sum;
  logic [BW-1:0]     sel_blinks;

  // Round-robin search: first set request at or after the pointer, wrapping.
  // The sum is one bit wider so a non-power-of-two N_REQ wraps correctly.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (!found && req_i[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_blinks = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == IW'(k)) sel_blinks = blinks_i[k*BW +: BW];
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q + PW'(1);
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = '0;
    led_d     = led_q;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        led_d   = 1'b0;
        busy_d  = 1'b0;
        if (found) begin
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          owner_d = pick;
          cnt_d   = sel_blinks;
          ptr_d   = (pick == IW'(N_REQ - 1)) ? '0 : pick + IW'(1);
          busy_d  = 1'b1;
          if (sel_blinks != '0) begin
            state_d = S_ON;
            led_d   = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_ON: begin
        if (presc_q == TICK_LAST) begin
          presc_d = '0;
          led_d   = 1'b0;
          cnt_d   = cnt_q - BW'(1);
          state_d = S_OFF;
        end
      end
      S_OFF: begin
        if (presc_q == TICK_LAST) begin
          presc_d = '0;
          if (cnt_q == '0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_ON;
            led_d   = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (presc_q == GAP_LAST) begin
          presc_d   = '0;
          done_d    = 1'b1;
          done_id_d = owner_q;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
        led_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      presc_q   <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;
  assign led_o     = led_q;

endmodule

// File: doc/led_blink_arbiter.md
Name: led_blink_arbiter

Overview:
- Shares one board LED between N_REQ requesters; each requester asks for a burst of 0..2^BW-1 blinks.
- Round-robin arbitration picks one requester, then an FSM with a prescaler plays the burst and a fixed separating gap.
- Completion is reported back to the owning requester.
- Sits between status/debug sources and the LED pin. The reset input is driven by the board's rst_gen instance.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- BW, 4, width of each blink-count field.
- TICK_DIV, 12_500_000, clock cycles per LED ON phase and per OFF phase (≥1).
- GAP_MULT, 2, gap length in units of TICK_DIV after each burst (≥1).

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- req_i  input  N_REQ  request level, one bit per requester; held high until granted.
- blinks_i  input  N_REQ*BW  blink count; requester k uses bits [k*BW +: BW].
- gnt_o  output  N_REQ  one-hot, one-cycle grant pulse.
- busy_o  output  1  high while a burst or gap is in progress.
- done_o  output  1  one-cycle pulse at the end of the gap.
- done_id_o  output  $clog2(N_REQ)  index of the finished owner; valid while done_o=1.
- led_o  output  1  LED drive, registered.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; the ports are named clk_i and rst_i.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, prescaler 0, blink counter 0.
- rst_i has priority over every other event, including mid-burst. On the next edge the LED is 0, state is IDLE and no done_o is produced.
- States: IDLE, ON, OFF, GAP.
- Prescaler width is $clog2(GAP_MULT*TICK_DIV).
- A phase ends on the cycle where the prescaler equals its limit-1. The prescaler clears on every state transition.
- IDLE, grant decision:
  - If req_i≠0, select the first set bit at or after the pointer, wrapping modulo N_REQ; call it i.
  - On that edge: gnt_o=onehot(i) for one cycle, latch owner=i, latch cnt=blinks_i[i] and set the pointer to (i+1) mod N_REQ.
  - If cnt≠0: state→ON and led_o→1. If cnt=0: state→GAP and led_o stays 0.
- IDLE lasts at least one cycle after each done_o, so back-to-back bursts are separated by gap plus 1 cycle.
- ON: led_o=1 for exactly TICK_DIV cycles. At the end: led_o→0, cnt→cnt-1, state→OFF.
- OFF: led_o=0 for TICK_DIV cycles. At the end: if cnt=0, state→GAP; else state→ON and led_o→1.
- GAP: led_o=0 for GAP_MULT*TICK_DIV cycles. At the end: done_o=1 and done_id_o=owner for one cycle, state→IDLE.
- busy_o=1 in ON, OFF and GAP; 0 in IDLE. It is registered together with the state.
- req_i and blinks_i are ignored outside IDLE. blinks_i is sampled only on the grant edge; later changes do not affect the running burst.
- A requester that drops req_i before being granted is simply skipped. A granted requester may keep req_i high and will be re-granted in round-robin order.
- cnt is never decremented below 0. Maximum burst is 2^BW-1 blinks.
- Burst duration, grant edge to done_o: 2*n*TICK_DIV + GAP_MULT*TICK_DIV cycles.

Test Plan:
Bench parameters: TICK_DIV=4, GAP_MULT=2, N_REQ=4, BW=4.
- Reset: rst_i high for 3 cycles with req_i=1111 → led_o, gnt_o, busy_o and done_o all stay 0; the first grant after release is gnt_o=0001.
- Single burst: req_i=0010, blinks for requester 1 = 3 → gnt_o=0010 for 1 cycle. Then led_o goes high 4 / low 4, three times, followed by 8 low cycles. done_o pulses 32 cycles after the grant with done_id_o=1, and busy_o falls with it.
- Round robin: req_i=1111 held, all blink counts 1 → grant order 0,1,2,3,0. Consecutive grants are 17 cycles apart (16 burst+gap, +1 IDLE).
- Zero blinks: req_i=0100, count 0 → gnt_o=0100, led_o never rises, done_o with done_id_o=2 after 8 cycles.
- Reset mid-ON: assert rst_i during the 2nd ON phase of a 5-blink burst → led_o=0 and busy_o=0 on the next edge, no done_o. The next grant starts from pointer 0.
- Input stability: change blinks_i and toggle req_i during a burst → burst length and owner are unchanged. The pending req is granted only after IDLE is entered.
